qbus_target: RTL

QBUS_TARGET -- requirements
Module: qbus_target

---
 rtl/qbus_target_pkg.sv | 27 ++
 rtl/qbus_tmr.sv | 32 +++
 rtl/qbus_target.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/qbus_target_pkg.sv
// Shared Q-bus target definitions: FSM state encoding, default window/timeout
// values and the byte-enable decode helper.
package qbus_target_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_DECODE,
      S_ACCESS,
      S_WAIT,
      S_REPLY,
      S_MISS
   } qbus_state_e;

   localparam logic [15:0] QBUS_DEF_BASE    = 16'o177000;
   localparam logic [15:0] QBUS_DEF_MASK    = 16'o177000;
   localparam int unsigned QBUS_DEF_TIMEOUT = 63;
   localparam int unsigned QBUS_TMR_W       = 16;

   // bit0 enables the low byte; a byte access selects one half by addr[0]
   function automatic logic [1:0] qbus_byte_en(input logic byte_acc, input logic a0);
      if (!byte_acc) begin
         return 2'b11;
      end
      return a0 ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/qbus_tmr.sv
// Loadable down-counter used for both the wait-state and the mem_ack timeout.
// Load wins over decrement; the count saturates at zero.
module qbus_tmr #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ce,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             dec,
   output logic [WIDTH-1:0] count,
   output logic             zero
);

   localparam logic [WIDTH-1:0] ONE = 1;

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (ce) begin
         if (load) begin
            count <= load_val;
         end else if (dec && (count != '0)) begin
            count <= count - ONE;
         end
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/qbus_target.sv
// Q-bus target: decodes an address window, forwards DIN/DOUT to a local
// memory port and answers with RPLY once the local side acknowledges.
module qbus_target
   import qbus_target_pkg::*;
#(
   parameter logic [15:0] BASE        = QBUS_DEF_BASE,
   parameter logic [15:0] MASK        = QBUS_DEF_MASK,
   parameter int unsigned WAIT_STATES = 0,
   parameter int unsigned TIMEOUT     = QBUS_DEF_TIMEOUT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ce,
   input  logic        SYNC,
   input  logic        DIN,
   input  logic        DOUT,
   input  logic        WTBT,
   input  logic [15:0] addr_i,
   input  logic [15:0] data_i,
   output logic [15:0] data_o,
   output logic        RPLY,
   output logic        hit,
   output logic [14:0] mem_addr,
   output logic [15:0] mem_wdata,
   output logic [1:0]  mem_be,
   output logic        mem_we,
   output logic        mem_re,
   input  logic [15:0] mem_rdata,
   input  logic        mem_ack,
   output logic        timeout_err
);

   localparam logic [QBUS_TMR_W-1:0] TMO_LOAD  = QBUS_TMR_W'(TIMEOUT);
   localparam logic [QBUS_TMR_W-1:0] WAIT_LOAD = QBUS_TMR_W'(WAIT_STATES);
   localparam logic [QBUS_TMR_W-1:0] ONE       = 1;

   qbus_state_e           state;
   logic [15:0]           rdata_q;
   logic                  addr_match;
   logic                  go_access;
   logic                  acc_ack;
   logic [QBUS_TMR_W-1:0] tmo_count;
   logic                  tmo_zero;
   logic                  tmo_expire;
   logic [QBUS_TMR_W-1:0] wait_count;
   logic                  wait_zero;
   logic                  wait_done;

   assign addr_match = ((addr_i & MASK) == (BASE & MASK));
   assign go_access  = (state == S_DECODE) && SYNC && hit && !(DIN && DOUT) && (DIN || DOUT);
   assign acc_ack    = (state == S_ACCESS) && SYNC && mem_ack;
   // Fire on the edge that would take the count to zero, so the pulse
   // appears exactly TIMEOUT (or WAIT_STATES) ce-cycles after the load.
   assign tmo_expire = tmo_zero || (tmo_count == ONE);
   assign wait_done  = wait_zero || (wait_count == ONE);

   qbus_tmr #(
      .WIDTH(QBUS_TMR_W)
   ) u_tmo_tmr (
      .clk     (clk),
      .reset   (reset),
      .ce      (ce),
      .load    (go_access),
      .load_val(TMO_LOAD),
      .dec     (state == S_ACCESS),
      .count   (tmo_count),
      .zero    (tmo_zero)
   );

   qbus_tmr #(
      .WIDTH(QBUS_TMR_W)
   ) u_wait_tmr (
      .clk     (clk),
      .reset   (reset),
      .ce      (ce),
      .load    (acc_ack),
      .load_val(WAIT_LOAD),
      .dec     (state == S_WAIT),
      .count   (wait_count),
      .zero    (wait_zero)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         RPLY        <= 1'b0;
         hit         <= 1'b0;
         data_o      <= '0;
         rdata_q     <= '0;
         mem_re      <= 1'b0;
         mem_we      <= 1'b0;
         mem_be      <= '0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         timeout_err <= 1'b0;
      end else if (ce) begin
         timeout_err <= 1'b0;
         case (state)
            S_IDLE: begin
               if (SYNC) begin
                  mem_addr <= addr_i[15:1];
                  mem_be   <= qbus_byte_en(WTBT, addr_i[0]);
                  hit      <= addr_match;
                  state    <= S_DECODE;
               end
            end
            S_DECODE: begin
               if (!SYNC) begin
                  hit   <= 1'b0;
                  state <= S_IDLE;
               end else if (!hit || (DIN && DOUT)) begin
                  state <= S_MISS;
               end else if (DIN || DOUT) begin
                  mem_re    <= DIN;
                  mem_we    <= DOUT;
                  mem_wdata <= data_i;
                  state     <= S_ACCESS;
               end
            end
            S_ACCESS: begin
               if (!SYNC) begin
                  mem_re <= 1'b0;
                  mem_we <= 1'b0;
                  hit    <= 1'b0;
                  state  <= S_IDLE;
               end else if (mem_ack) begin
                  mem_re  <= 1'b0;
                  mem_we  <= 1'b0;
                  rdata_q <= mem_re ? mem_rdata : '0;
                  if (WAIT_STATES > 0) begin
                     state <= S_WAIT;
                  end else begin
                     RPLY   <= 1'b1;
                     data_o <= mem_re ? mem_rdata : '0;
                     state  <= S_REPLY;
                  end
               end else if (tmo_expire) begin
                  timeout_err <= 1'b1;
                  mem_re      <= 1'b0;
                  mem_we      <= 1'b0;
                  state       <= S_MISS;
               end
            end
            S_WAIT: begin
               if (!SYNC) begin
                  hit   <= 1'b0;
                  state <= S_IDLE;
               end else if (wait_done) begin
                  RPLY   <= 1'b1;
                  data_o <= rdata_q;
                  state  <= S_REPLY;
               end
            end
            S_REPLY: begin
               if (!DIN && !DOUT) begin
                  RPLY   <= 1'b0;
                  data_o <= '0;
                  if (SYNC) begin
                     state <= S_DECODE;
                  end else begin
                     hit   <= 1'b0;
                     state <= S_IDLE;
                  end
               end
            end
            S_MISS: begin
               if (!SYNC) begin
                  hit   <= 1'b0;
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
